// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding an asynchronous UART transmitter through a start/busy handshake.
// A watchdog returns the sequencer to idle if the transmitter never acknowledges a start.
module uart_tx_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          clr_ovf,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_tx_start;
    logic [7:0]    r_tx_data;
    logic [1:0]    r_wd;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full && !flush;
    assign w_pop   = (r_state == IDLE) && !w_empty && !tx_busy && !flush;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end
            // A dropped write beats a same-cycle clear so no overflow event is lost.
            if (wr_en && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Watchdog spans the START cycle plus three WAIT_BUSY cycles without tx_busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_wd       <= '0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rptr];
                        r_tx_start <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_wd    <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_wd == 2'd2) begin
                        r_state <= IDLE;
                    end else begin
                        r_wd <= r_wd + 2'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: vector table, directed corner sequences, and a randomized
// run checked against a queue-based reference of the transmit queue.
module tb_uart_tx_queue;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          flush = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         st_cyc[$];
    logic [7:0] st_dat[$];
    bit         hold_busy = 1'b0;
    bit         xm_busy   = 1'b0;
    int         xm_left   = 0;
    int         xm_len    = 0;

    // Reference: queue contents, sticky flag and transfer age since the pop.
    logic [7:0] m_q[$];
    bit         m_ovf, m_st, m_inflight, m_hs;
    logic [7:0] m_dat;
    int         m_age;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       fl;
        logic       clr;
        logic       busy;
        int         e_cnt;
        logic       e_empty;
        logic       e_full;
        logic       e_ovf;
        logic       e_start;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge; record starts and run the transmitter model.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (tx_start) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(tx_data);
        end
        if (xm_left > 0) begin
            xm_busy = 1'b1;
            xm_left--;
        end else begin
            xm_busy = 1'b0;
        end
        if (tx_start && xm_len > 0) xm_left = xm_len;
        tx_busy = hold_busy | xm_busy;
    endtask

    task automatic set_hold(input bit b);
        hold_busy = b;
        tx_busy   = hold_busy | xm_busy;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        hold_busy = 1'b0; xm_len = 0; xm_left = 0; xm_busy = 1'b0; tx_busy = 1'b0;
        cycle();
        rst = 1'b0;
        tx_busy = 1'b0;
        st_cyc.delete();
        st_dat.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " count"},    int'(count), 0);
        chk({tag, " empty"},    int'(empty), 1);
        chk({tag, " full"},     int'(full), 0);
        chk({tag, " overflow"}, int'(overflow), 0);
        chk({tag, " tx_start"}, int'(tx_start), 0);
        chk({tag, " tx_data"},  int'(tx_data), 0);
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            cycle();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        for (int i = 0; i < budget && st_cyc.size() < n; i++) cycle();
        chk({name, " start seen in time"}, int'(st_cyc.size() >= n), 1);
    endtask

    function automatic int st_at(input int i);
        return (i < st_dat.size()) ? int'(st_dat[i]) : -1;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < st_cyc.size()) ? st_cyc[i] : -1000;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0; m_st = 1'b0; m_inflight = 1'b0; m_hs = 1'b0;
        m_dat = 8'h00; m_age = 0;
    endtask

    task automatic model_step();
        bit pop, push;
        if (rst) begin
            model_reset();
            return;
        end
        pop  = !m_inflight && m_q.size() > 0 && !tx_busy && !flush;
        push = wr_en && m_q.size() < DEPTH && !flush;
        if (wr_en && m_q.size() == DEPTH) m_ovf = 1'b1;
        else if (clr_ovf)                 m_ovf = 1'b0;
        if (m_inflight) begin
            if (m_age == 1) begin
                m_age = 2;
            end else if (m_hs) begin
                if (!tx_busy) m_inflight = 1'b0;
            end else begin
                if (tx_busy) m_hs = 1'b1;
                else if (m_age == 4) m_inflight = 1'b0;
                m_age++;
            end
        end
        if (pop) begin
            m_dat      = m_q.pop_front();
            m_inflight = 1'b1;
            m_age      = 1;
            m_hs       = 1'b0;
        end
        m_st = pop;
        if (flush)     m_q.delete();
        else if (push) m_q.push_back(wr_data);
    endtask

    task automatic check_model();
        chk("rand count",    int'(count), m_q.size());
        chk("rand full",     int'(full), int'(m_q.size() == DEPTH));
        chk("rand empty",    int'(empty), int'(m_q.size() == 0));
        chk("rand overflow", int'(overflow), int'(m_ovf));
        chk("rand tx_start", int'(tx_start), int'(m_st));
        chk("rand tx_data",  int'(tx_data), int'(m_dat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44};
        vecs[6]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h44};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};

        do_reset();
        check_reset("reset");

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr; wr_data = vecs[i].d; flush = vecs[i].fl; clr_ovf = vecs[i].clr;
            set_hold(vecs[i].busy);
            cycle();
            chk($sformatf("vec%0d count", i),    int'(count),    vecs[i].e_cnt);
            chk($sformatf("vec%0d empty", i),    int'(empty),    int'(vecs[i].e_empty));
            chk($sformatf("vec%0d full", i),     int'(full),     int'(vecs[i].e_full));
            chk($sformatf("vec%0d overflow", i), int'(overflow), int'(vecs[i].e_ovf));
            chk($sformatf("vec%0d tx_start", i), int'(tx_start), int'(vecs[i].e_start));
            chk($sformatf("vec%0d tx_data", i),  int'(tx_data),  int'(vecs[i].e_data));
        end
        wr_en = 1'b0; flush = 1'b0; clr_ovf = 1'b0; set_hold(1'b0);

        // Single byte with a 10-cycle busy response.
        do_reset();
        xm_len = 10;
        push_bytes(8'hA5, 1);
        chk("single count after push", int'(count), 1);
        cycle();
        chk("single count after pop", int'(count), 0);
        repeat (25) cycle();
        chk("single start count", st_cyc.size(), 1);
        chk("single data", st_at(0), 8'hA5);
        chk("single empty", int'(empty), 1);

        // Fill, overflow, simultaneous push/pop at full, ordered drain.
        do_reset();
        set_hold(1'b1);
        xm_len = 3;
        push_bytes(8'h00, 17);
        chk("fill full", int'(full), 1);
        chk("fill count", int'(count), 16);
        chk("fill overflow", int'(overflow), 1);
        wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
        cycle();
        wr_en = 1'b0;
        chk("ovf set beats clear", int'(overflow), 1);
        cycle();
        clr_ovf = 1'b0;
        chk("ovf cleared", int'(overflow), 0);
        wr_en = 1'b1; wr_data = 8'h99;
        set_hold(1'b0);
        cycle();
        wr_en = 1'b0;
        chk("push+pop at full count", int'(count), 15);
        chk("push+pop at full overflow", int'(overflow), 1);
        wait_starts(16, 400, "drain");
        for (int i = 0; i < 16; i++) chk($sformatf("drain order %0d", i), st_at(i), i);
        repeat (10) cycle();
        chk("drain start total", st_cyc.size(), 16);
        chk("drain empty", int'(empty), 1);

        // Flush while the first byte is in WAIT_DONE.
        do_reset();
        set_hold(1'b1);
        push_bytes(8'h31, 5);
        xm_len = 6;
        set_hold(1'b0);
        wait_starts(1, 20, "flush first");
        repeat (3) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush count", int'(count), 0);
        chk("flush empty", int'(empty), 1);
        repeat (30) cycle();
        chk("flush no more starts", st_cyc.size(), 1);
        chk("flush first data", st_at(0), 8'h31);
        push_bytes(8'h77, 1);
        wait_starts(2, 30, "after flush");
        chk("after flush data", st_at(1), 8'h77);

        // Watchdog path: transmitter never raises busy.
        do_reset();
        set_hold(1'b1);
        push_bytes(8'h61, 2);
        set_hold(1'b0);
        wait_starts(2, 40, "watchdog");
        chk("watchdog spacing", cyc_at(1) - cyc_at(0), 5);
        chk("watchdog data0", st_at(0), 8'h61);
        chk("watchdog data1", st_at(1), 8'h62);

        // Reset in WAIT_BUSY with bytes still queued.
        do_reset();
        set_hold(1'b1);
        push_bytes(8'h81, 3);
        xm_len = 5;
        set_hold(1'b0);
        wait_starts(1, 20, "midreset");
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_reset("midreset");
        repeat (20) cycle();
        chk("midreset no further start", st_cyc.size(), 1);

        // Randomized run against the reference.
        do_reset();
        model_reset();
        for (int it = 0; it < 1500; it++) begin
            rst     = ($urandom_range(0, 199) == 0);
            wr_en   = ($urandom_range(0, 9) < 6);
            wr_data = 8'($urandom);
            flush   = ($urandom_range(0, 49) == 0);
            clr_ovf = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) set_hold(!hold_busy);
            xm_len = $urandom_range(0, 6);
            model_step();
            cycle();
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
